gf_addsub_lanes: RTL and testbench

//   Multi-lane pipelined modular add/sub/negate over GF(MODULUS); operands must be reduced (< MODULUS).

---
 rtl/gf_addsub_lanes.sv | 122 ++++++++++++
 tb/tb_gf_addsub_lanes.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_addsub_lanes.sv
// Multi-lane two-stage modular add/sub/negate/pass over GF(MODULUS) with valid/ready flow control.
// Operands are expected reduced; out-of-range operands raise a per-lane err flag.
module gf_addsub_lanes #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MODULUS = 32'hec940e71,
    parameter int               LANES   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [1:0]               i_op,
    input  logic [LANES*WIDTH-1:0]   i_a,
    input  logic [LANES*WIDTH-1:0]   i_b,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [LANES*WIDTH-1:0]   o_out,
    output logic [LANES-1:0]         o_err
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_NEG  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    localparam logic [WIDTH:0] MOD_X = {1'b0, MODULUS};

    logic             s1_valid;
    logic             s1_load;
    logic             s2_load;
    op_e              op_in;
    op_e              s1_op;
    logic [WIDTH:0]   r_c   [LANES];
    logic [WIDTH:0]   r2_c  [LANES];
    logic [WIDTH:0]   s1_r  [LANES];
    logic [WIDTH:0]   s1_r2 [LANES];
    logic [LANES-1:0] err_c;
    logic [LANES-1:0] s1_err;
    logic [LANES-1:0] pick_c;
    logic [LANES*WIDTH-1:0] sel_c;

    // Bubble-collapsing advance: a stage fills whenever the stage after it can move.
    assign s2_load = !o_valid | i_ready;
    assign s1_load = !s1_valid | s2_load;
    assign o_ready = s1_load;
    assign op_in   = op_e'(i_op);

    // S1: raw result and its single correction candidate, one extra bit for carry/borrow.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            // NOTE: every always_comb output gets a default before the case, so no latch is inferred.
            r_c[k]   = '0;
            r2_c[k]  = '0;
            err_c[k] = (i_a[k*WIDTH +: WIDTH] >= MODULUS) |
                       ((i_b[k*WIDTH +: WIDTH] >= MODULUS) & ~i_op[1]);
            case (op_in)
                OP_ADD: begin
                    r_c[k]  = {1'b0, i_a[k*WIDTH +: WIDTH]} + {1'b0, i_b[k*WIDTH +: WIDTH]};
                    r2_c[k] = r_c[k] - MOD_X;
                end
                OP_SUB: begin
                    r_c[k]  = {1'b0, i_a[k*WIDTH +: WIDTH]} - {1'b0, i_b[k*WIDTH +: WIDTH]};
                    r2_c[k] = r_c[k] + MOD_X;
                end
                OP_NEG: begin
                    r_c[k]  = {(WIDTH+1){1'b0}} - {1'b0, i_a[k*WIDTH +: WIDTH]};
                    r2_c[k] = r_c[k] + MOD_X;
                end
                default: begin
                    r_c[k]  = {1'b0, i_a[k*WIDTH +: WIDTH]};
                    r2_c[k] = {1'b0, i_a[k*WIDTH +: WIDTH]};
                end
            endcase
        end
    end

    // S2: choose the corrected value on overflow (add) or borrow (sub/neg).
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            case (s1_op)
                OP_ADD:         pick_c[k] = (s1_r[k] >= MOD_X);
                OP_SUB, OP_NEG: pick_c[k] = s1_r[k][WIDTH];
                default:        pick_c[k] = 1'b0;
            endcase
            sel_c[k*WIDTH +: WIDTH] = pick_c[k] ? s1_r2[k][WIDTH-1:0] : s1_r[k][WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state always uses non-blocking assignment so all registers update together.
        if (i_rst) begin
            s1_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_out    <= '0;
            o_err    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= i_valid;
            end
            if (s2_load) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_out <= sel_c;
                    o_err <= s1_err;
                end
            end
        end
    end

    // NOTE: the S1 data registers are deliberately left without reset; s1_valid qualifies them.
    always_ff @(posedge i_clk) begin
        if (s1_load && i_valid) begin
            s1_op  <= op_in;
            s1_r   <= r_c;
            s1_r2  <= r2_c;
            s1_err <= err_c;
        end
    end

endmodule

// File: tb/tb_gf_addsub_lanes.sv
// Bench for gf_addsub_lanes: modular-arithmetic scoreboard checked every cycle, plus directed
// vectors with hand-computed results, streaming under random backpressure, stall and reset cases.
module tb_gf_addsub_lanes;

    localparam int          W = 32;
    localparam int          L = 4;
    localparam logic [31:0] M = 32'hec940e71;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [1:0]     i_op;
    logic [L*W-1:0] i_a;
    logic [L*W-1:0] i_b;
    logic           o_valid;
    logic           i_ready;
    logic [L*W-1:0] o_out;
    logic [L-1:0]   o_err;

    typedef struct packed {
        logic [L*W-1:0] out;
        logic [L-1:0]   err;
    } beat_t;

    beat_t          exp_q[$];
    int             n_pass = 0;
    int             n_total = 0;
    int             n_consumed = 0;
    bit             mon_en = 1'b0;
    bit             prev_stall = 1'b0;
    logic [L*W-1:0] prev_out;
    logic [L-1:0]   prev_err;
    bit             stream_done;

    gf_addsub_lanes #(.WIDTH(W), .MODULUS(M), .LANES(L)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_out   (o_out),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [L*W-1:0] pk(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Field arithmetic on plain integers; results truncated to the lane width.
    function automatic beat_t model(input logic [1:0] op, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        beat_t res;
        longint unsigned x, y, r, m;
        m = longint'(M);
        for (int k = 0; k < L; k++) begin
            x = longint'(a[k*W +: W]);
            y = longint'(b[k*W +: W]);
            case (op)
                2'd0: begin r = x + y; if (r >= m) r = r - m; end
                2'd1: r = (x >= y) ? x - y : x - y + m;
                2'd2: r = (x == 0) ? 0 : m - x;
                default: r = x;
            endcase
            res.out[k*W +: W] = r[31:0];
            res.err[k] = (x >= m) || ((y >= m) && (op < 2'd2));
        end
        return res;
    endfunction

    // Scoreboard: push on accept, pop and compare on consume, and hold-check while stalled.
    always @(negedge clk) begin
        if (mon_en) begin
            if (i_rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", L*W'(o_valid), L*W'(1));
                    check("stall_out_held", o_out, prev_out);
                    check("stall_err_held", L*W'(o_err), L*W'(prev_err));
                end
                if (i_valid && o_ready) exp_q.push_back(model(i_op, i_a, i_b));
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", L*W'(1), L*W'(0));
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("sb_out", o_out, e.out);
                        check("sb_err", L*W'(o_err), L*W'(e.err));
                        n_consumed++;
                    end
                end
                prev_stall = o_valid && !i_ready;
                prev_out   = o_out;
                prev_err   = o_err;
            end
        end
    end

    // Present one beat, hold it until accepted; returns just after the accepting edge.
    task automatic put(input logic [1:0] op, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        bit acc;
        acc = 1'b0;
        i_valid = 1'b1;
        i_op = op;
        i_a = a;
        i_b = b;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!acc) check("put_accept_timeout", L*W'(0), L*W'(1));
    endtask

    task automatic wait_valid(input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = o_valid;
        end
        if (!got) check(name, L*W'(0), L*W'(1));
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [L*W-1:0] a,
                           input logic [L*W-1:0] b, input logic [L*W-1:0] eo, input logic [L-1:0] ee);
        i_ready = 1'b1;
        put(op, a, b);
        wait_valid({name, "_timeout"});
        check({name, "_out"}, o_out, eo);
        check({name, "_err"}, L*W'(o_err), L*W'(ee));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sv(input int n, input int k, input longint unsigned salt);
        longint unsigned v;
        v = (longint'(n) * 64'h09e3779b + longint'(k) * 64'h7f4a7c15 + salt) % longint'(M);
        return v[31:0];
    endfunction

    initial begin
        int n;
        int c0;
        logic [L*W-1:0] sa, sb;

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_op = 2'd0; i_a = '0; i_b = '0;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        check("rst_o_valid", L*W'(o_valid), L*W'(0));
        check("rst_o_out", o_out, '0);
        check("rst_o_err", L*W'(o_err), L*W'(0));
        check("rst_o_ready", L*W'(o_ready), L*W'(1));
        mon_en = 1'b1;

        // Add with wrap and without, and exact 2-cycle latency.
        i_ready = 1'b1;
        put(2'd0, pk(32'hec940e70, 32'h76000000, 32'h0, 32'h12345678),
                  pk(32'h00000001, 32'h76000000, 32'h0, 32'h00000001));
        check("lat_not_at_1", L*W'(o_valid), L*W'(0));
        @(posedge clk);
        #1;
        check("lat_valid_at_2", L*W'(o_valid), L*W'(1));
        check("add_out", o_out, pk(32'h0, 32'hec000000, 32'h0, 32'h12345679));
        check("add_err", L*W'(o_err), L*W'(0));
        @(posedge clk);
        #1;

        run_one("sub", 2'd1, pk(32'h0, 32'h5, 32'hec940e70, 32'h100),
                             pk(32'h1, 32'h3, 32'hec940e70, 32'h200),
                             pk(32'hec940e70, 32'h2, 32'h0, 32'hec940d71), 4'b0000);
        run_one("neg", 2'd2, pk(32'h0, 32'h1, 32'hec940e70, 32'h5),
                             pk(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff),
                             pk(32'h0, 32'hec940e70, 32'h1, 32'hec940e6c), 4'b0000);
        run_one("pass", 2'd3, pk(32'h1234, 32'h0, 32'hec940e70, 32'h42),
                              pk(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff),
                              pk(32'h1234, 32'h0, 32'hec940e70, 32'h42), 4'b0000);
        run_one("lanes", 2'd0, pk(32'hec940e70, 32'h1, 32'hffffffff, 32'h0),
                               pk(32'h5, 32'h2, 32'h0, 32'hec940e71),
                               pk(32'h4, 32'h3, 32'h136bf18e, 32'h0), 4'b1100);

        // Stream 16 beats with valid held high against random backpressure.
        c0 = n_consumed;
        stream_done = 1'b0;
        n = 0;
        fork
            begin
                for (int cyc = 0; cyc < 400 && n < 16; cyc++) begin
                    for (int k = 0; k < L; k++) begin
                        sa[k*W +: W] = sv(n, k, 64'h1111);
                        sb[k*W +: W] = sv(n + 7, k, 64'hec94_0000);
                    end
                    i_valid = 1'b1;
                    i_op = 2'(n % 4);
                    i_a = sa;
                    i_b = sb;
                    @(negedge clk);
                    if (o_ready) n++;
                    @(posedge clk);
                    #1;
                end
                i_valid = 1'b0;
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    i_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        check("stream_accepted", L*W'(n), L*W'(16));
        i_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("stream_drained", L*W'(exp_q.size()), L*W'(0));
        check("stream_count", L*W'(n_consumed - c0), L*W'(16));
        @(posedge clk);
        #1;

        // Full pipeline under stall: third beat refused, then in-order drain.
        i_ready = 1'b0;
        put(2'd0, pk(32'h1, 32'h2, 32'h3, 32'h4), '0);
        put(2'd3, pk(32'haa, 32'hbb, 32'hcc, 32'hdd), '0);
        i_valid = 1'b1;
        i_op = 2'd0;
        i_a = pk(32'h9, 32'h9, 32'h9, 32'h9);
        i_b = '0;
        repeat (3) begin
            @(negedge clk);
            check("full_o_ready_low", L*W'(o_ready), L*W'(0));
            check("full_o_valid", L*W'(o_valid), L*W'(1));
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check("drain_first_valid", L*W'(o_valid), L*W'(1));
        check("drain_first_out", o_out, pk(32'h1, 32'h2, 32'h3, 32'h4));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_second_valid", L*W'(o_valid), L*W'(1));
        check("drain_second_out", o_out, pk(32'haa, 32'hbb, 32'hcc, 32'hdd));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_empty", L*W'(o_valid), L*W'(0));
        @(posedge clk);
        #1;

        // Reset with one beat in each stage: both are dropped.
        i_ready = 1'b0;
        put(2'd0, pk(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff), '0);
        put(2'd1, pk(32'h7, 32'h7, 32'h7, 32'h7), pk(32'h1, 32'h1, 32'h1, 32'h1));
        check("pre_rst_valid", L*W'(o_valid), L*W'(1));
        check("pre_rst_err", L*W'(o_err), L*W'(4'hf));
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        check("post_rst_o_valid", L*W'(o_valid), L*W'(0));
        check("post_rst_o_out", o_out, '0);
        check("post_rst_o_err", L*W'(o_err), L*W'(0));
        check("post_rst_o_ready", L*W'(o_ready), L*W'(1));
        i_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_no_beat", L*W'(o_valid), L*W'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
